// File: rtl/dfx_seq_engine_if.sv
// Command/completion channel between the sequencer engine and the DFX/DMA datapath.
// The engine drives the master side; the datapath drives the slave side.
interface dfx_seq_engine_if #(
    parameter int SRC_ADDR_WIDTH = 32,
    parameter int SRC_SIZE_WIDTH = 26,
    parameter int DST_ADDR_WIDTH = 32,
    parameter int DST_SIZE_WIDTH = 26
);
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic [SRC_ADDR_WIDTH-1:0] cmd_src_addr;
    logic [SRC_SIZE_WIDTH-1:0] cmd_src_size;
    logic [DST_ADDR_WIDTH-1:0] cmd_des_addr;
    logic [DST_SIZE_WIDTH-1:0] cmd_des_size;
    logic                      done_valid;
    logic                      done_err;

    modport master (
        output cmd_valid, cmd_src_addr, cmd_src_size, cmd_des_addr, cmd_des_size,
        input  cmd_ready, done_valid, done_err
    );

    modport slave (
        input  cmd_valid, cmd_src_addr, cmd_src_size, cmd_des_addr, cmd_des_size,
        output cmd_ready, done_valid, done_err
    );
endinterface

// File: rtl/dfx_seq_engine.sv
// Slot-table sequencer: walks rows 0..endCnt, issues one DFX/DMA command per row,
// times its completion and writes per-slot status/profile back to the bank1 table.
module dfx_seq_engine #(
    parameter int INDEX_WIDTH       = 2,
    parameter int SRC_ADDR_WIDTH    = 32,
    parameter int SRC_SIZE_WIDTH    = 26,
    parameter int DST_ADDR_WIDTH    = 32,
    parameter int DST_SIZE_WIDTH    = 26,
    parameter int SLOT_STATUS_WIDTH = 2,
    parameter int PROFILE_WIDTH     = 32,
    parameter int CONTROL_WIDTH     = 4,
    parameter int STATUS_WIDTH      = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [CONTROL_WIDTH-1:0]     ext_bank0_inp_control,
    input  logic                         ext_bank0_set_control,
    input  logic [INDEX_WIDTH-1:0]       ext_bank0_inp_endCnt,
    input  logic                         ext_bank0_set_endCnt,
    output logic [STATUS_WIDTH-1:0]      bank0_status,
    output logic [INDEX_WIDTH-1:0]       bank0_cnt,
    output logic [INDEX_WIDTH-1:0]       bank0_endCnt,
    output logic [INDEX_WIDTH-1:0]       slot_rd_index,
    input  logic [SRC_ADDR_WIDTH-1:0]    slot_rd_src_addr,
    input  logic [SRC_SIZE_WIDTH-1:0]    slot_rd_src_size,
    input  logic [DST_ADDR_WIDTH-1:0]    slot_rd_des_addr,
    input  logic [DST_SIZE_WIDTH-1:0]    slot_rd_des_size,
    output logic [INDEX_WIDTH-1:0]       slot_wr_index,
    output logic [SLOT_STATUS_WIDTH-1:0] slot_wr_status,
    output logic                         slot_set_status,
    output logic [PROFILE_WIDTH-1:0]     slot_wr_profile,
    output logic                         slot_set_profile,
    dfx_seq_engine_if.master             cmd_if
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH1 = 3'd1,
        S_FETCH2 = 3'd2,
        S_ISSUE  = 3'd3,
        S_WAIT   = 3'd4,
        S_WB     = 3'd5
    } state_e;

    localparam logic [STATUS_WIDTH-1:0] ST_BUSY    = STATUS_WIDTH'(4'b0001);
    localparam logic [STATUS_WIDTH-1:0] ST_DONE    = STATUS_WIDTH'(4'b0010);
    localparam logic [STATUS_WIDTH-1:0] ST_ABORTED = STATUS_WIDTH'(4'b0100);
    localparam logic [STATUS_WIDTH-1:0] ST_ERROR   = STATUS_WIDTH'(4'b1000);

    state_e                         state_q, state_d;
    logic [INDEX_WIDTH-1:0]         cnt_q, cnt_d;
    logic [INDEX_WIDTH-1:0]         endcnt_q, endcnt_d;
    logic [STATUS_WIDTH-1:0]        status_q, status_d;
    logic                           abort_q, abort_d;
    logic                           err_q, err_d;
    logic [PROFILE_WIDTH-1:0]       prof_q, prof_d;
    logic [SRC_ADDR_WIDTH-1:0]      src_addr_q, src_addr_d;
    logic [SRC_SIZE_WIDTH-1:0]      src_size_q, src_size_d;
    logic [DST_ADDR_WIDTH-1:0]      des_addr_q, des_addr_d;
    logic [DST_SIZE_WIDTH-1:0]      des_size_q, des_size_d;
    logic                           cmd_valid_q, cmd_valid_d;
    logic                           wb_set_q, wb_set_d;
    logic [SLOT_STATUS_WIDTH-1:0]   wb_status_q, wb_status_d;
    logic [PROFILE_WIDTH-1:0]       wb_profile_q, wb_profile_d;

    logic start_req_s, stop_req_s, halt_s, timing_s, unused_ctrl_s;

    // STOP dominates START when both are written together
    assign stop_req_s    = ext_bank0_set_control & ext_bank0_inp_control[1];
    assign start_req_s   = ext_bank0_set_control & ext_bank0_inp_control[0] & ~ext_bank0_inp_control[1];
    assign halt_s        = err_q | abort_q | stop_req_s | (cnt_q == endcnt_q);
    assign timing_s      = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign unused_ctrl_s = ^ext_bank0_inp_control[CONTROL_WIDTH-1:2];

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = start_req_s ? S_FETCH1 : S_IDLE;
            S_FETCH1: state_d = stop_req_s ? S_IDLE : S_FETCH2;
            S_FETCH2: state_d = stop_req_s ? S_IDLE : S_ISSUE;
            S_ISSUE:  state_d = cmd_if.cmd_ready ? S_WAIT : S_ISSUE;
            S_WAIT:   state_d = cmd_if.done_valid ? S_WB : S_WAIT;
            S_WB:     state_d = halt_s ? S_IDLE : S_FETCH1;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        cnt_d        = cnt_q;
        endcnt_d     = endcnt_q;
        status_d     = status_q;
        abort_d      = abort_q;
        err_d        = err_q;
        src_addr_d   = src_addr_q;
        src_size_d   = src_size_q;
        des_addr_d   = des_addr_q;
        des_size_d   = des_size_q;
        cmd_valid_d  = (state_d == S_ISSUE);
        wb_set_d     = (state_d == S_WB);
        wb_status_d  = '0;
        wb_profile_d = '0;
        case (state_q)
            S_IDLE: begin
                if (ext_bank0_set_endCnt) endcnt_d = ext_bank0_inp_endCnt;
                else                      endcnt_d = endcnt_q;
                if (start_req_s) begin
                    status_d = ST_BUSY;
                    cnt_d    = '0;
                    abort_d  = 1'b0;
                    err_d    = 1'b0;
                end else begin
                    status_d = status_q;
                end
            end
            S_FETCH1: begin
                if (stop_req_s) status_d = ST_ABORTED;
                else            status_d = status_q;
            end
            S_FETCH2: begin
                if (stop_req_s) begin
                    status_d = ST_ABORTED;
                end else begin
                    src_addr_d = slot_rd_src_addr;
                    src_size_d = slot_rd_src_size;
                    des_addr_d = slot_rd_des_addr;
                    des_size_d = slot_rd_des_size;
                end
            end
            S_ISSUE: begin
                if (stop_req_s) abort_d = 1'b1;
                else            abort_d = abort_q;
            end
            S_WAIT: begin
                if (stop_req_s) abort_d = 1'b1;
                else            abort_d = abort_q;
                // write-back payload is captured here so WB drives it from flops
                if (cmd_if.done_valid) begin
                    err_d        = cmd_if.done_err;
                    wb_status_d  = SLOT_STATUS_WIDTH'({1'b1, cmd_if.done_err});
                    wb_profile_d = prof_q;
                end else begin
                    err_d        = err_q;
                end
            end
            S_WB: begin
                if (err_q) begin
                    status_d = ST_ERROR;
                end else if (abort_q || stop_req_s) begin
                    status_d = ST_ABORTED;
                    abort_d  = 1'b0;
                end else if (cnt_q == endcnt_q) begin
                    status_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + INDEX_WIDTH'(1);
                end
            end
            default: begin
                status_d = status_q;
            end
        endcase

        // Latency counter: 1 in the first ISSUE cycle, frozen on the done cycle
        if (state_d == S_ISSUE && state_q != S_ISSUE) begin
            prof_d = PROFILE_WIDTH'(1);
        end else if (timing_s && (state_d == S_ISSUE || state_d == S_WAIT) && (prof_q != '1)) begin
            prof_d = prof_q + PROFILE_WIDTH'(1);
        end else begin
            prof_d = prof_q;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q        <= '0;
            endcnt_q     <= '0;
            status_q     <= '0;
            abort_q      <= 1'b0;
            err_q        <= 1'b0;
            prof_q       <= '0;
            src_addr_q   <= '0;
            src_size_q   <= '0;
            des_addr_q   <= '0;
            des_size_q   <= '0;
            cmd_valid_q  <= 1'b0;
            wb_set_q     <= 1'b0;
            wb_status_q  <= '0;
            wb_profile_q <= '0;
        end else begin
            cnt_q        <= cnt_d;
            endcnt_q     <= endcnt_d;
            status_q     <= status_d;
            abort_q      <= abort_d;
            err_q        <= err_d;
            prof_q       <= prof_d;
            src_addr_q   <= src_addr_d;
            src_size_q   <= src_size_d;
            des_addr_q   <= des_addr_d;
            des_size_q   <= des_size_d;
            cmd_valid_q  <= cmd_valid_d;
            wb_set_q     <= wb_set_d;
            wb_status_q  <= wb_status_d;
            wb_profile_q <= wb_profile_d;
        end
    end

    assign bank0_status        = status_q;
    assign bank0_cnt           = cnt_q;
    assign bank0_endCnt        = endcnt_q;
    assign slot_rd_index       = cnt_q;
    assign slot_wr_index       = cnt_q;
    assign slot_wr_status      = wb_status_q;
    assign slot_set_status     = wb_set_q;
    assign slot_wr_profile     = wb_profile_q;
    assign slot_set_profile    = wb_set_q;
    assign cmd_if.cmd_valid    = cmd_valid_q;
    assign cmd_if.cmd_src_addr = src_addr_q;
    assign cmd_if.cmd_src_size = src_size_q;
    assign cmd_if.cmd_des_addr = des_addr_q;
    assign cmd_if.cmd_des_size = des_size_q;
endmodule

// File: tb/tb_dfx_seq_engine.sv
// Bench for dfx_seq_engine: a transaction-level slot table / datapath model
// predicts commands and write-backs; directed runs pin status, counts and profiles.
module tb_dfx_seq_engine;
    logic        clk;
    logic        reset;
    logic [3:0]  ctrl_in;
    logic        set_ctrl;
    logic [1:0]  endcnt_in;
    logic        set_end;
    logic [3:0]  bank0_status;
    logic [1:0]  bank0_cnt, bank0_endcnt, slot_rd_index, slot_wr_index;
    logic [31:0] rd_src_addr, rd_des_addr;
    logic [25:0] rd_src_size, rd_des_size;
    logic [1:0]  slot_wr_status;
    logic        slot_set_status, slot_set_profile;
    logic [31:0] slot_wr_profile;

    dfx_seq_engine_if #(.SRC_ADDR_WIDTH(32), .SRC_SIZE_WIDTH(26),
                        .DST_ADDR_WIDTH(32), .DST_SIZE_WIDTH(26)) cmd_if ();

    dfx_seq_engine dut (
        .clk(clk), .reset(reset),
        .ext_bank0_inp_control(ctrl_in), .ext_bank0_set_control(set_ctrl),
        .ext_bank0_inp_endCnt(endcnt_in), .ext_bank0_set_endCnt(set_end),
        .bank0_status(bank0_status), .bank0_cnt(bank0_cnt), .bank0_endCnt(bank0_endcnt),
        .slot_rd_index(slot_rd_index),
        .slot_rd_src_addr(rd_src_addr), .slot_rd_src_size(rd_src_size),
        .slot_rd_des_addr(rd_des_addr), .slot_rd_des_size(rd_des_size),
        .slot_wr_index(slot_wr_index), .slot_wr_status(slot_wr_status),
        .slot_set_status(slot_set_status), .slot_wr_profile(slot_wr_profile),
        .slot_set_profile(slot_set_profile), .cmd_if(cmd_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // slot table contents and datapath behaviour knobs
    logic [31:0] t_src_addr [0:3];
    logic [25:0] t_src_size [0:3];
    logic [31:0] t_des_addr [0:3];
    logic [25:0] t_des_size [0:3];
    int ready_stall, done_delay, err_slot, run_end;

    // model state
    int cyc = 0, prev_idx = 0, exp_slot = 0, ncmds = 0, nwb = 0, valid_cycles = 0;
    int issue_cyc = 0, done_at = -1, stall_cnt = 0, wb_slot = 0;
    bit in_issue = 1'b0, wb_err = 1'b0;
    logic [31:0] exp_profile = 32'd0, last_profile = 32'd0;
    logic [1:0]  last_wb_status = 2'b00;

    // Slot-table read port, command consumer, completion generator and compare process
    initial begin
        cmd_if.cmd_ready = 1'b0; cmd_if.done_valid = 1'b0; cmd_if.done_err = 1'b0;
        rd_src_addr = 32'd0; rd_src_size = 26'd0; rd_des_addr = 32'd0; rd_des_size = 26'd0;
        forever begin
            @(negedge clk);
            cyc++;
            // read data reflects the index seen one cycle earlier
            rd_src_addr = t_src_addr[prev_idx]; rd_src_size = t_src_size[prev_idx];
            rd_des_addr = t_des_addr[prev_idx]; rd_des_size = t_des_size[prev_idx];
            prev_idx = int'(slot_rd_index);
            cmd_if.cmd_ready = 1'b0; cmd_if.done_valid = 1'b0; cmd_if.done_err = 1'b0;
            if (!reset) begin
                in_issue = 1'b0;
                done_at  = -1;
            end else begin
                if (slot_set_status) begin
                    check("wb_index", 32'(slot_wr_index), 32'(wb_slot));
                    check("wb_status", 32'(slot_wr_status), wb_err ? 32'd3 : 32'd2);
                    check("wb_profile", slot_wr_profile, exp_profile);
                    check("wb_set_profile", 32'(slot_set_profile), 32'd1);
                    nwb++;
                    last_profile   = slot_wr_profile;
                    last_wb_status = slot_wr_status;
                end
                if (cmd_if.cmd_valid) begin
                    int s;
                    s = exp_slot % 4;
                    valid_cycles++;
                    if (!in_issue) begin
                        in_issue  = 1'b1;
                        issue_cyc = cyc;
                        stall_cnt = 0;
                    end
                    check("cmd_src_addr", cmd_if.cmd_src_addr, t_src_addr[s]);
                    check("cmd_src_size", 32'(cmd_if.cmd_src_size), 32'(t_src_size[s]));
                    check("cmd_des_addr", cmd_if.cmd_des_addr, t_des_addr[s]);
                    check("cmd_des_size", 32'(cmd_if.cmd_des_size), 32'(t_des_size[s]));
                    if (stall_cnt >= ready_stall) begin
                        cmd_if.cmd_ready = 1'b1;
                        check("cmd_beyond_end", (exp_slot > run_end) ? 32'd1 : 32'd0, 32'd0);
                        done_at  = cyc + done_delay;
                        wb_slot  = s;
                        wb_err   = (exp_slot == err_slot);
                        exp_slot++;
                        ncmds++;
                        in_issue = 1'b0;
                    end else begin
                        stall_cnt++;
                    end
                end else if (in_issue) begin
                    check("cmd_valid_held", 32'(cmd_if.cmd_valid), 32'd1);
                    in_issue = 1'b0;
                end
                if (cyc == done_at) begin
                    cmd_if.done_valid = 1'b1;
                    cmd_if.done_err   = wb_err;
                    exp_profile       = 32'(cyc - issue_cyc + 1);
                end
            end
        end
    end

    task automatic write_ctrl(input logic [3:0] v);
        @(negedge clk); ctrl_in = v; set_ctrl = 1'b1;
        @(negedge clk); set_ctrl = 1'b0; ctrl_in = 4'd0;
    endtask

    task automatic write_endcnt(input logic [1:0] v);
        @(negedge clk); endcnt_in = v; set_end = 1'b1;
        @(negedge clk); set_end = 1'b0;
    endtask

    task automatic start_run(input int last);
        run_end  = last;
        exp_slot = 0;
        write_ctrl(4'b0001);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bank0_status[0] && n < 500) begin @(negedge clk); n++; end
        if (n >= 500) begin
            checks++; errors++;
            $display("FAIL idle_timeout actual=busy required=idle");
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!cmd_if.cmd_valid && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) begin
            checks++; errors++;
            $display("FAIL valid_timeout actual=0 required=1");
        end
    endtask

    int c0, w0;

    initial begin
        for (int i = 0; i < 4; i++) begin
            t_src_addr[i] = 32'h1000_0000 + 32'(i) * 32'h0000_0110;
            t_src_size[i] = 26'h000_0040 + 26'(i) * 26'h000_0008;
            t_des_addr[i] = 32'h8000_F000 - 32'(i) * 32'h0000_1000;
            t_des_size[i] = 26'h3FF_F000 + 26'(i);
        end
        ctrl_in = 4'd0; set_ctrl = 1'b0; endcnt_in = 2'd0; set_end = 1'b0;
        ready_stall = 0; done_delay = 5; err_slot = -1; run_end = 0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_status", 32'(bank0_status), 32'd0);
        check("rst_cnt", 32'(bank0_cnt), 32'd0);
        check("rst_endcnt", 32'(bank0_endcnt), 32'd0);
        check("rst_cmd_valid", 32'(cmd_if.cmd_valid), 32'd0);
        check("rst_wb_strobe", 32'(slot_set_status), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // three slots, immediate accept, done 5 cycles after accept
        c0 = ncmds; w0 = nwb;
        write_endcnt(2'd2);
        start_run(2);
        wait_idle();
        check("t1_cmds", 32'(ncmds - c0), 32'd3);
        check("t1_wbs", 32'(nwb - w0), 32'd3);
        check("t1_profile", last_profile, 32'd6);
        check("t1_status", 32'(bank0_status), 32'b0010);
        check("t1_cnt", 32'(bank0_cnt), 32'd2);

        // single slot with 4 stall cycles before accept
        c0 = ncmds; valid_cycles = 0; ready_stall = 4; done_delay = 3;
        write_endcnt(2'd0);
        start_run(0);
        wait_idle();
        check("t2_cmds", 32'(ncmds - c0), 32'd1);
        check("t2_valid_cycles", 32'(valid_cycles), 32'd5);
        check("t2_profile", last_profile, 32'd8);
        check("t2_status", 32'(bank0_status), 32'b0010);
        check("t2_cnt", 32'(bank0_cnt), 32'd0);

        // transfer error on slot 1
        c0 = ncmds; ready_stall = 0; done_delay = 2; err_slot = 1;
        write_endcnt(2'd3);
        start_run(3);
        wait_idle();
        check("t3_cmds", 32'(ncmds - c0), 32'd2);
        check("t3_wb_status", 32'(last_wb_status), 32'd3);
        check("t3_profile", last_profile, 32'd3);
        check("t3_status", 32'(bank0_status), 32'b1000);
        check("t3_cnt", 32'(bank0_cnt), 32'd1);

        // STOP during WAIT of slot 0
        c0 = ncmds; w0 = nwb; err_slot = -1; done_delay = 8;
        start_run(3);
        wait_valid();
        repeat (3) @(negedge clk);
        write_ctrl(4'b0010);
        wait_idle();
        check("t4_cmds", 32'(ncmds - c0), 32'd1);
        check("t4_wbs", 32'(nwb - w0), 32'd1);
        check("t4_wb_status", 32'(last_wb_status), 32'd2);
        check("t4_status", 32'(bank0_status), 32'b0100);
        check("t4_cnt", 32'(bank0_cnt), 32'd0);

        // START+STOP together, then STOP alone, while idle
        c0 = ncmds;
        write_ctrl(4'b0011);
        repeat (4) @(negedge clk);
        check("t5_startstop_status", 32'(bank0_status), 32'b0100);
        write_ctrl(4'b0010);
        repeat (4) @(negedge clk);
        check("t5_stop_idle_status", 32'(bank0_status), 32'b0100);
        check("t5_cmds", 32'(ncmds - c0), 32'd0);

        // endCnt write and START while busy are ignored
        c0 = ncmds; done_delay = 6;
        write_endcnt(2'd1);
        start_run(1);
        wait_valid();
        write_endcnt(2'd3);
        write_ctrl(4'b0001);
        check("t6_endcnt_busy", 32'(bank0_endcnt), 32'd1);
        wait_idle();
        check("t6_cmds", 32'(ncmds - c0), 32'd2);
        check("t6_status", 32'(bank0_status), 32'b0010);
        check("t6_cnt", 32'(bank0_cnt), 32'd1);
        check("t6_endcnt", 32'(bank0_endcnt), 32'd1);

        // reset in ISSUE, then a full 4-slot run
        ready_stall = 20;
        write_endcnt(2'd2);
        start_run(2);
        wait_valid();
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("t7_rst_cmd_valid", 32'(cmd_if.cmd_valid), 32'd0);
        check("t7_rst_status", 32'(bank0_status), 32'd0);
        check("t7_rst_cnt", 32'(bank0_cnt), 32'd0);
        check("t7_rst_endcnt", 32'(bank0_endcnt), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        c0 = ncmds; w0 = nwb; ready_stall = 0; done_delay = 2;
        write_endcnt(2'd3);
        start_run(3);
        wait_idle();
        check("t7_cmds", 32'(ncmds - c0), 32'd4);
        check("t7_wbs", 32'(nwb - w0), 32'd4);
        check("t7_status", 32'(bank0_status), 32'b0010);
        check("t7_cnt", 32'(bank0_cnt), 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
